// File: rtl/if_id_stage_if.sv
// Fetch/decode-side signal bundle of the IF/ID stage.
// The slave view belongs to the stage; the master view is the fetch block plus decoder.
interface if_id_stage_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
);
  logic [N-1:0]  instr_in;
  logic [N-1:0]  pc_in;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [N-1:0]  instr_out;
  logic [N-1:0]  pc_out;
  logic [N-1:0]  pc_plus8_out;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] stall_cycles;

  modport slave (
    input  instr_in, pc_in, in_valid, flush, out_ready,
    output in_ready, instr_out, pc_out, pc_plus8_out, out_valid, stall_cycles
  );

  modport master (
    output instr_in, pc_in, in_valid, flush, out_ready,
    input  in_ready, instr_out, pc_out, pc_plus8_out, out_valid, stall_cycles
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: 2-entry skid buffer between fetch and decode, with branch
// flush, PC+8 derivation and a saturating decode back-pressure counter.
module if_id_stage #(
  parameter int unsigned    N         = 32,
  parameter int unsigned    CW        = 16,
  parameter logic [N-1:0]   NOP_INSTR = 32'hE1A00000
) (
  input  logic       clk,
  input  logic       rst,
  if_id_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  main_instr, main_pc;
  logic [N-1:0]  skid_instr, skid_pc;
  logic [CW-1:0] stall_cnt;

  logic in_ready, out_valid;
  logic accept, issue;

  // in_ready depends only on state and rst, keeping input and output handshakes decoupled
  always_comb begin
    in_ready  = (state != FULL) && rst;
    out_valid = (state != EMPTY) && rst;
    accept    = bus.in_valid && in_ready && !bus.flush;
    issue     = out_valid && bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !issue)      state_nxt = FULL;
        else if (!accept && issue) state_nxt = EMPTY;
      end
      FULL:    if (issue) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (bus.flush) state_nxt = EMPTY;
  end

  always_comb begin
    bus.in_ready     = in_ready;
    bus.out_valid    = out_valid;
    bus.instr_out    = out_valid ? main_instr : NOP_INSTR;
    bus.pc_out       = rst ? main_pc : '0;
    bus.pc_plus8_out = bus.pc_out + N'(8);
    bus.stall_cycles = stall_cnt;
  end

  // Data moves only on real transfers; flush leaves the stale words in place.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_instr <= '0;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (!bus.flush) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_instr <= bus.instr_in;
            main_pc    <= bus.pc_in;
          end
        end
        ONE: begin
          if (accept && issue) begin
            main_instr <= bus.instr_in;
            main_pc    <= bus.pc_in;
          end else if (accept) begin
            skid_instr <= bus.instr_in;
            skid_pc    <= bus.pc_in;
          end
        end
        FULL: begin
          if (issue) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (out_valid && !bus.out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CW'(1);
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: vector table for reset/stream/back-pressure/flush,
// hand sequences for steady-state streaming, counter saturation, mid-run reset and PC wrap.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'hE1A00000;
  localparam logic [31:0] A0  = 32'hAA000000;
  localparam logic [31:0] A1  = 32'hAA000001;
  localparam logic [31:0] A2  = 32'hAA000002;
  localparam logic [31:0] A3  = 32'hAA000003;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  if_id_stage_if #(.N(32), .CW(4)) bus ();

  if_id_stage #(.N(32), .CW(4), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, iv, fl, ordy;
    logic [31:0] pc, ins;
    logic        eov, eir;
    logic [31:0] epc, einstr;
    logic [3:0]  est;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(logic r, logic iv, logic [31:0] pc, logic [31:0] ins,
                              logic fl, logic ordy, logic eov, logic eir,
                              logic [31:0] epc, logic [31:0] einstr, logic [3:0] est);
    vec_t v;
    v.r = r; v.iv = iv; v.pc = pc; v.ins = ins; v.fl = fl; v.ordy = ordy;
    v.eov = eov; v.eir = eir; v.epc = epc; v.einstr = einstr; v.est = est;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic iv, logic [31:0] pc, logic [31:0] ins,
                       logic fl, logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.pc_in     = pc;
    bus.instr_in  = ins;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(string tag, logic eov, logic eir, logic [31:0] epc,
                            logic [31:0] einstr, logic [3:0] est);
    check($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'(eov));
    check($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'(eir));
    check($sformatf("%s.pc_out", tag), bus.pc_out, epc);
    check($sformatf("%s.pc_plus8", tag), bus.pc_plus8_out, epc + 32'd8);
    check($sformatf("%s.instr_out", tag), bus.instr_out, einstr);
    check($sformatf("%s.stall", tag), 32'(bus.stall_cycles), 32'(est));
  endtask

  initial begin
    logic [3:0] est;

    //          r  iv pc      ins fl ordy | ov ir pc      instr st
    tv[0]  = mk(0, 0, 32'h0,  A0, 0, 0,     0, 0, 32'h0,  NOP, 0);
    tv[1]  = mk(0, 0, 32'h0,  A0, 0, 0,     0, 0, 32'h0,  NOP, 0);
    tv[2]  = mk(1, 1, 32'h0,  A0, 0, 1,     1, 1, 32'h0,  A0,  0);
    tv[3]  = mk(1, 1, 32'h4,  A1, 0, 1,     1, 1, 32'h4,  A1,  0);
    tv[4]  = mk(1, 1, 32'h8,  A2, 0, 1,     1, 1, 32'h8,  A2,  0);
    tv[5]  = mk(1, 0, 32'h0,  A0, 0, 1,     0, 1, 32'h8,  NOP, 0);
    tv[6]  = mk(1, 1, 32'h0,  A0, 0, 0,     1, 1, 32'h0,  A0,  0);
    tv[7]  = mk(1, 1, 32'h4,  A1, 0, 0,     1, 0, 32'h0,  A0,  1);
    tv[8]  = mk(1, 1, 32'h8,  A2, 0, 0,     1, 0, 32'h0,  A0,  2);
    tv[9]  = mk(1, 1, 32'h8,  A2, 0, 0,     1, 0, 32'h0,  A0,  3);
    tv[10] = mk(1, 1, 32'h8,  A2, 0, 1,     1, 1, 32'h4,  A1,  3);
    tv[11] = mk(1, 1, 32'h8,  A2, 0, 1,     1, 1, 32'h8,  A2,  3);
    tv[12] = mk(1, 0, 32'h0,  A0, 0, 1,     0, 1, 32'h8,  NOP, 3);
    tv[13] = mk(1, 1, 32'h0,  A0, 0, 0,     1, 1, 32'h0,  A0,  3);
    tv[14] = mk(1, 1, 32'h4,  A1, 0, 0,     1, 0, 32'h0,  A0,  4);
    tv[15] = mk(1, 1, 32'h8,  A2, 1, 0,     0, 1, 32'h0,  NOP, 5);
    tv[16] = mk(1, 0, 32'h0,  A0, 0, 1,     0, 1, 32'h0,  NOP, 5);

    drive(0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].r, tv[i].iv, tv[i].pc, tv[i].ins, tv[i].fl, tv[i].ordy);
      step();
      check_outs($sformatf("vec%0d", i), tv[i].eov, tv[i].eir, tv[i].epc,
                 tv[i].einstr, tv[i].est);
    end

    // Steady-state streaming: one instruction per cycle, in_ready never drops.
    drive(1, 1, 32'h100, 32'hBB000000, 0, 1);
    step();
    check_outs("stream0", 1, 1, 32'h100, 32'hBB000000, 5);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 1, 32'h100 + 32'(4 * i), 32'hBB000000 + 32'(i), 0, 1);
      step();
      check_outs($sformatf("stream%0d", i), 1, 1, 32'h100 + 32'(4 * i),
                 32'hBB000000 + 32'(i), 5);
    end
    drive(1, 0, '0, '0, 0, 1);
    step();
    check_outs("stream_drain", 0, 1, 32'h128, NOP, 5);

    // Counter saturation: hold one entry under back-pressure for 20 cycles.
    drive(1, 1, 32'h200, A1, 0, 0);
    step();
    check_outs("sat_load", 1, 1, 32'h200, A1, 5);
    est = 4'd5;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, '0, '0, 0, 0);
      step();
      if (est != 4'd15) est = est + 4'd1;
      check_outs($sformatf("sat%0d", i), 1, 1, 32'h200, A1, est);
    end

    // Fill to FULL, then a one-cycle reset discards both entries.
    drive(1, 1, 32'h204, A2, 0, 0);
    step();
    check_outs("pre_rst_full", 1, 0, 32'h200, A1, 15);
    drive(0, 0, '0, '0, 1, 1);
    step();
    check_outs("mid_rst", 0, 0, 32'h0, NOP, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, '0, '0, 0, 1);
      step();
      check_outs($sformatf("post_rst%0d", i), 0, 1, 32'h0, NOP, 0);
    end

    // PC wrap on the +8 output.
    drive(1, 1, 32'hFFFFFFFC, A3, 0, 0);
    step();
    check_outs("pc_wrap", 1, 1, 32'hFFFFFFFC, A3, 0);
    check("pc_wrap_abs", bus.pc_plus8_out, 32'h00000004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
